// File: rtl/secded_pkg.sv
// secded_pkg: shared types and elaboration-time helpers for the pipelined
// SECDED corrector (extended Hamming code, data bits on the non-power-of-two
// codeword positions, parity bit i on position 2^i).
package secded_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK        = 2'd0,
    ST_CORR_DATA = 2'd1,
    ST_CORR_CHK  = 2'd2,
    ST_UNCORR    = 2'd3
  } status_e;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // Codeword position (1-based) of data bit idx: the idx-th non-power-of-two.
  function automatic int data_pos(input int idx, input int data_w);
    int seen;
    int result;
    seen   = 0;
    result = 0;
    for (int pos = 1; pos <= data_w + calc_p(data_w); pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (seen == idx) result = pos;
        seen++;
      end
    end
    return result;
  endfunction

  // Data bits covered by Hamming parity bit bit_i (position has bit bit_i set).
  function automatic logic [63:0] parity_mask(input int bit_i, input int data_w);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < data_w; k++) begin
      if (((data_pos(k, data_w) >> bit_i) & 1) != 0) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// secded_syndrome: combinational syndrome / overall-parity generator.
// With chk tied to zero the s output is the Hamming parity of the data, so
// the same block doubles as an encoder.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int P      = calc_p(DATA_W),
  localparam int CHK_W  = P + 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic [CHK_W-1:0]  chk,
  output logic [P-1:0]      s,
  output logic              o
);

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_par
      localparam logic [63:0] MASK = parity_mask(gi, DATA_W);
      // Recomputed parity over the covered data bits, folded with the received bit.
      assign s[gi] = (^(data & MASK[DATA_W-1:0])) ^ chk[gi];
    end
  endgenerate

  // Overall parity across every received bit; 1 means an odd number of flips.
  assign o = (^data) ^ (^chk);

endmodule

// File: rtl/secded_pipe_corrector.sv
// secded_pipe_corrector: two-stage pipelined SECDED corrector with
// valid/ready flow control, per-beat status, error position and saturating
// error counters.
//   S1: registers the received word and its syndrome.
//   S2: registers the corrected word, status and error position.
// Optional build macro SECDED_ERR_INJECT_EN adds inj_en/inj_pos, which flip
// one codeword bit of an accepted beat ahead of the syndrome logic.
module secded_pipe_corrector
  import secded_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int CHK_W  = P + 1
) (
  input  logic                Gclk,
  input  logic                Grst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [CHK_W-1:0]    in_chk,
  input  logic                chk_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [STATUS_W-1:0] out_status,
  output logic [P-1:0]        out_err_pos,
  output logic [CNT_W-1:0]    corr_cnt,
  output logic [CNT_W-1:0]    uncorr_cnt,
  input  logic                cnt_clr
`ifdef SECDED_ERR_INJECT_EN
  ,
  input  logic                inj_en,
  input  logic [P-1:0]        inj_pos
`endif
);

  localparam int          N   = DATA_W + P;
  localparam logic [P-1:0] N_V = P'(N);

  // Handshake / pipeline control
  logic rdy_en_reg;
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s2_load_ok;
  logic s1_adv;
  logic in_acc;
  logic out_xfer;

  // Stage 1 state
  logic [DATA_W-1:0] s1_data_reg;
  logic [P-1:0]      s1_s_reg;
  logic              s1_o_reg;
  logic              s1_chk_en_reg;

  // Stage 2 state
  logic [DATA_W-1:0] s2_data_reg;
  status_e           s2_status_reg;
  logic [P-1:0]      s2_pos_reg;

  // Counters
  logic [CNT_W-1:0] corr_cnt_reg;
  logic [CNT_W-1:0] uncorr_cnt_reg;

  // Datapath nets
  logic [DATA_W-1:0] data_cw;
  logic [CHK_W-1:0]  chk_cw;
  logic [P-1:0]      syn_s;
  logic              syn_o;
  logic [DATA_W-1:0] flip_mask;
  logic [DATA_W-1:0] corr_data;
  status_e           corr_status;
  logic [P-1:0]      corr_pos;
  logic              s_is_chk_pos;
  logic              out_counted_corr;
  logic              out_counted_uncorr;

  // S2 may load when empty or when its beat leaves this cycle; S1 drains into it.
  assign out_xfer   = s2_valid_reg & out_ready;
  assign s2_load_ok = ~s2_valid_reg | out_ready;
  assign s1_adv     = s1_valid_reg & s2_load_ok;
  assign in_ready   = rdy_en_reg & (~s1_valid_reg | s2_load_ok);
  assign in_acc     = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_data
      localparam logic [P-1:0] DPOS = P'(data_pos(gi, DATA_W));
      // Correction selects the data bit whose position equals the syndrome.
      assign flip_mask[gi] = (s1_s_reg == DPOS);
`ifdef SECDED_ERR_INJECT_EN
      assign data_cw[gi] = in_data[gi] ^ (inj_en & (inj_pos == DPOS));
`else
      assign data_cw[gi] = in_data[gi];
`endif
    end

    for (gi = 0; gi < P; gi++) begin : g_chk
`ifdef SECDED_ERR_INJECT_EN
      localparam logic [P-1:0] CPOS = P'(1 << gi);
      assign chk_cw[gi] = in_chk[gi] ^ (inj_en & (inj_pos == CPOS));
`else
      assign chk_cw[gi] = in_chk[gi];
`endif
    end
  endgenerate

  // The overall parity bit has no codeword position, so it is never injected.
  assign chk_cw[P] = in_chk[P];

  secded_syndrome #(
    .DATA_W (DATA_W)
  ) u_syndrome (
    .data (data_cw),
    .chk  (chk_cw),
    .s    (syn_s),
    .o    (syn_o)
  );

  // in_ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge Gclk or posedge Grst) begin
    if (Grst) rdy_en_reg <= 1'b0;
    else      rdy_en_reg <= 1'b1;
  end

  // Stage 1: capture the accepted beat and its syndrome.
  always_ff @(posedge Gclk or posedge Grst) begin
    if (Grst) begin
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
      s1_s_reg      <= '0;
      s1_o_reg      <= 1'b0;
      s1_chk_en_reg <= 1'b0;
    end else begin
      if (in_acc) begin
        s1_valid_reg  <= 1'b1;
        s1_data_reg   <= data_cw;
        s1_s_reg      <= syn_s;
        s1_o_reg      <= syn_o;
        s1_chk_en_reg <= chk_en;
      end else if (s1_adv) begin
        s1_valid_reg  <= 1'b0;
      end
    end
  end

  // Syndrome 0 or a single set bit points at a check bit (or the overall bit).
  assign s_is_chk_pos = ((s1_s_reg & (s1_s_reg - P'(1))) == '0);

  // Classify the S1 beat and build the corrected word.
  always_comb begin
    corr_data   = s1_data_reg;
    corr_status = ST_OK;
    corr_pos    = '0;
    if (s1_chk_en_reg) begin
      if (!s1_o_reg) begin
        if (s1_s_reg != '0) corr_status = ST_UNCORR;
      end else if (s_is_chk_pos) begin
        corr_status = ST_CORR_CHK;
        corr_pos    = s1_s_reg;
      end else if (s1_s_reg > N_V) begin
        corr_status = ST_UNCORR;
      end else begin
        corr_data   = s1_data_reg ^ flip_mask;
        corr_status = ST_CORR_DATA;
        corr_pos    = s1_s_reg;
      end
    end
  end

  // Stage 2: hold the result until the downstream takes it.
  always_ff @(posedge Gclk or posedge Grst) begin
    if (Grst) begin
      s2_valid_reg  <= 1'b0;
      s2_data_reg   <= '0;
      s2_status_reg <= ST_OK;
      s2_pos_reg    <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid_reg  <= 1'b1;
        s2_data_reg   <= corr_data;
        s2_status_reg <= corr_status;
        s2_pos_reg    <= corr_pos;
      end else if (out_xfer) begin
        s2_valid_reg  <= 1'b0;
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_data    = s2_data_reg;
  assign out_status  = s2_status_reg;
  assign out_err_pos = s2_pos_reg;

  // Counting on the output transfer means a stalled beat is counted exactly once.
  assign out_counted_corr   = out_xfer &
                              ((s2_status_reg == ST_CORR_DATA) || (s2_status_reg == ST_CORR_CHK));
  assign out_counted_uncorr = out_xfer & (s2_status_reg == ST_UNCORR);

  // Corrected-beat counter: clear wins, saturates at all-ones.
  always_ff @(posedge Gclk or posedge Grst) begin
    if (Grst)                                       corr_cnt_reg <= '0;
    else if (cnt_clr)                               corr_cnt_reg <= '0;
    else if (out_counted_corr && corr_cnt_reg != '1) corr_cnt_reg <= corr_cnt_reg + 1'b1;
  end

  // Uncorrectable-beat counter: clear wins, saturates at all-ones.
  always_ff @(posedge Gclk or posedge Grst) begin
    if (Grst)                                            uncorr_cnt_reg <= '0;
    else if (cnt_clr)                                    uncorr_cnt_reg <= '0;
    else if (out_counted_uncorr && uncorr_cnt_reg != '1) uncorr_cnt_reg <= uncorr_cnt_reg + 1'b1;
  end

  assign corr_cnt   = corr_cnt_reg;
  assign uncorr_cnt = uncorr_cnt_reg;

endmodule

// File: tb/tb_secded_pipe_corrector.sv
// tb_secded_pipe_corrector: table-driven directed vectors, hand-written stall,
// saturation, clear and reset sequences, and a randomized run against a
// codeword-level reference model (syndrome = XOR of the positions of set bits).
module tb_secded_pipe_corrector;

  localparam int DATA_W = 32;
  localparam int P      = 6;
  localparam int N      = DATA_W + P;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] BASE = 32'hDEADBEEF;

  logic              Gclk;
  logic              Grst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic [6:0]        in_chk;
  logic              chk_en;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [1:0]        out_status;
  logic [5:0]        out_err_pos;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;
  logic              cnt_clr;

  logic [31:0]       enc_d;
  logic [5:0]        enc_s;
  logic              enc_o;

  secded_pipe_corrector #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .Gclk        (Gclk),
    .Grst        (Grst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_chk      (in_chk),
    .chk_en      (chk_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_status  (out_status),
    .out_err_pos (out_err_pos),
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt),
    .cnt_clr     (cnt_clr)
`ifdef SECDED_ERR_INJECT_EN
    ,
    .inj_en      (1'b0),
    .inj_pos     (6'd0)
`endif
  );

  secded_syndrome #(
    .DATA_W (DATA_W)
  ) u_enc (
    .data (enc_d),
    .chk  (7'd0),
    .s    (enc_s),
    .o    (enc_o)
  );

  initial Gclk = 1'b0;
  always #5 Gclk = ~Gclk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  st;
    logic [5:0]  pos;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [6:0]  cf;
    logic        en;
    logic [31:0] xd;
    logic [1:0]  xs;
    logic [5:0]  xp;
    int          cc;
    int          uc;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   m_corr = 0;
  int   m_unc = 0;
  int   n_delivered = 0;
  bit   stall_prev = 0;
  bit   saw_not_ready = 0;
  logic [31:0] held_data;
  vec_t tbl [12];

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Encoder: Hamming bits are the XOR of the positions holding a 1.
  function automatic logic [6:0] enc(input logic [31:0] d);
    int k;
    int syn;
    logic [6:0] c;
    k = 0;
    syn = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if (!is_pow2(pos)) begin
        if (d[k]) syn = syn ^ pos;
        k++;
      end
    end
    c[5:0] = syn[5:0];
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  // Expected decoder output from the received word.
  function automatic exp_t model(input logic [31:0] d, input logic [6:0] c, input logic en);
    logic cw [0:63];
    int   syn;
    logic ov;
    int   k;
    exp_t r;
    for (int i = 0; i < 64; i++) cw[i] = 1'b0;
    k = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if (is_pow2(pos)) cw[pos] = c[$clog2(pos)];
      else begin cw[pos] = d[k]; k++; end
    end
    syn = 0;
    ov = c[6];
    for (int pos = 1; pos <= N; pos++) begin
      if (cw[pos]) syn = syn ^ pos;
      ov = ov ^ cw[pos];
    end
    r.d = d;
    r.st = 2'd0;
    r.pos = 6'd0;
    if (en) begin
      if (!ov) begin
        if (syn != 0) r.st = 2'd3;
      end else if (syn == 0 || is_pow2(syn)) begin
        r.st = 2'd2;
        r.pos = 6'(syn);
      end else if (syn > N) begin
        r.st = 2'd3;
      end else begin
        cw[syn] = ~cw[syn];
        k = 0;
        for (int pos = 1; pos <= N; pos++) begin
          if (!is_pow2(pos)) begin r.d[k] = cw[pos]; k++; end
        end
        r.st = 2'd1;
        r.pos = 6'(syn);
      end
    end
    return r;
  endfunction

  // Flip codeword position pos of {chk,data}; pos 0 is the overall parity bit.
  function automatic logic [38:0] flip(input logic [38:0] dc, input int pos);
    logic [38:0] r;
    int k;
    r = dc;
    k = 0;
    if (pos == 0) r[38] = ~r[38];
    else begin
      for (int p = 1; p <= N; p++) begin
        if (is_pow2(p)) begin
          if (p == pos) r[32 + $clog2(p)] = ~r[32 + $clog2(p)];
        end else begin
          if (p == pos) r[k] = ~r[k];
          k++;
        end
      end
    end
    return r;
  endfunction

  // Returns {chk_en, chk, data}.
  function automatic logic [39:0] make_beat(input bit corr_only);
    logic [31:0] d;
    logic [38:0] dc;
    logic        en;
    int          nf;
    d = $urandom();
    dc = {enc(d), d};
    if (corr_only) begin
      nf = $urandom_range(31);
      dc[nf] = ~dc[nf];
      en = 1'b1;
    end else begin
      en = ($urandom_range(9) != 0);
      nf = $urandom_range(3);
      for (int i = 0; i < nf; i++) dc = flip(dc, $urandom_range(N));
    end
    return {en, dc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: called at a negedge with inputs already driven.
  task automatic cycle(output bit acc);
    exp_t e;
    bit   xfer;
    #1;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    if (!in_ready) saw_not_ready = 1;
    if (stall_prev) begin
      check("stall_hold_valid", out_valid, 1);
      check("stall_hold_data", out_data, held_data);
    end
    stall_prev = out_valid && !out_ready;
    held_data  = out_data;
    if (xfer) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_beat: got data %0h with no beat outstanding", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_status", out_status, e.st);
        check("out_err_pos", out_err_pos, e.pos);
        $display("beat out data=%h status=%0d pos=%0d", out_data, out_status, out_err_pos);
        n_delivered++;
        if (e.st == 2'd1 || e.st == 2'd2) begin
          if (m_corr < CNT_MAX) m_corr++;
        end else if (e.st == 2'd3) begin
          if (m_unc < CNT_MAX) m_unc++;
        end
      end
    end
    if (cnt_clr) begin
      m_corr = 0;
      m_unc = 0;
    end
    if (acc) sb.push_back(model(in_data, in_chk, chk_en));
    @(posedge Gclk);
    @(negedge Gclk);
    check("corr_cnt", corr_cnt, m_corr);
    check("uncorr_cnt", uncorr_cnt, m_unc);
  endtask

  task automatic run(input int nbeats, input bit corr_only, input int valid_pct,
                     input int ready_pct, input int clr_pct);
    int sent;
    int cyc;
    bit acc;
    logic [39:0] b;
    sent = 0;
    cyc = 0;
    while ((sent < nbeats || sb.size() > 0) && cyc < 3000) begin
      b = make_beat(corr_only);
      in_valid  = (sent < nbeats) && ($urandom_range(99) < valid_pct);
      in_data   = b[31:0];
      in_chk    = b[38:32];
      chk_en    = b[39];
      out_ready = ($urandom_range(99) < ready_pct);
      cnt_clr   = ($urandom_range(99) < clr_pct);
      cycle(acc);
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic clear_counters();
    bit acc;
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    cycle(acc);
    cnt_clr  = 1'b0;
  endtask

  initial begin
    bit acc;
    logic [31:0] bd [4];
    logic [6:0]  bc [4];
    logic [39:0] b;
    int d0;
    int bi;
    int guard;

    tbl[0]  = '{32'hDEADBEEF, 7'h00, 1'b1, 32'hDEADBEEF, 2'd0, 6'd0,  0, 0};
    tbl[1]  = '{32'hDEADBECF, 7'h00, 1'b1, 32'hDEADBEEF, 2'd1, 6'd10, 1, 0};
    tbl[2]  = '{32'hDEADBEEC, 7'h00, 1'b1, 32'hDEADBEEC, 2'd3, 6'd0,  1, 1};
    tbl[3]  = '{32'hDEADBEEC, 7'h00, 1'b0, 32'hDEADBEEC, 2'd0, 6'd0,  1, 1};
    tbl[4]  = '{32'hDEADBEEF, 7'h04, 1'b1, 32'hDEADBEEF, 2'd2, 6'd4,  2, 1};
    tbl[5]  = '{32'hDEADBEEF, 7'h40, 1'b1, 32'hDEADBEEF, 2'd2, 6'd0,  3, 1};
    tbl[6]  = '{32'h5EADBEEF, 7'h00, 1'b1, 32'hDEADBEEF, 2'd1, 6'd38, 4, 1};
    tbl[7]  = '{32'hDEADBEFF, 7'h00, 1'b1, 32'hDEADBEEF, 2'd1, 6'd9,  5, 1};
    tbl[8]  = '{32'hDEADBEEF, 7'h68, 1'b1, 32'hDEADBEEF, 2'd3, 6'd0,  5, 2};
    tbl[9]  = '{32'hDEADBECF, 7'h01, 1'b1, 32'hDEADBECF, 2'd3, 6'd0,  5, 3};
    tbl[10] = '{32'hDEADBEEF, 7'h03, 1'b1, 32'hDEADBEEF, 2'd3, 6'd0,  5, 4};
    tbl[11] = '{32'hDEADBEEE, 7'h00, 1'b1, 32'hDEADBEEF, 2'd1, 6'd3,  6, 4};

    Grst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_chk = '0;
    chk_en = 1'b1;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    enc_d = '0;
    repeat (2) @(negedge Gclk);

    // Reset state.
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_status", out_status, 0);
    check("reset_err_pos", out_err_pos, 0);
    check("reset_corr_cnt", corr_cnt, 0);
    check("reset_uncorr_cnt", uncorr_cnt, 0);
    Grst = 1'b0;
    #1;
    check("release_in_ready_low", in_ready, 0);
    @(posedge Gclk);
    @(negedge Gclk);
    check("release_in_ready_high", in_ready, 1);

    // Encoder sub-module against the bench encoder.
    for (int i = 0; i < 8; i++) begin
      enc_d = (i == 0) ? BASE : $urandom();
      #1;
      check("enc_parity", enc_s, enc(enc_d) & 7'h3f);
      check("enc_overall", enc_o, ^enc_d);
    end
    @(negedge Gclk);

    // Directed table: latency, result fields, running counter totals.
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      in_data   = tbl[i].d;
      in_chk    = enc(BASE) ^ tbl[i].cf;
      chk_en    = tbl[i].en;
      out_ready = 1'b1;
      cycle(acc);
      check("tbl_accept", acc, 1);
      in_valid = 1'b0;
      check("tbl_lat_s1_only", out_valid, 0);
      cycle(acc);
      check("tbl_lat_valid", out_valid, 1);
      check("tbl_data", out_data, tbl[i].xd);
      check("tbl_status", out_status, tbl[i].xs);
      check("tbl_pos", out_err_pos, tbl[i].xp);
      cycle(acc);
      check("tbl_corr_cnt", corr_cnt, tbl[i].cc);
      check("tbl_uncorr_cnt", uncorr_cnt, tbl[i].uc);
      $display("vec %0d data=%h status=%0d pos=%0d", i, tbl[i].d, tbl[i].xs, tbl[i].xp);
    end

    // Four back-to-back beats with out_ready low for cycles 2..4.
    clear_counters();
    for (int i = 0; i < 4; i++) begin
      b = make_beat(1'b1);
      bd[i] = b[31:0];
      bc[i] = b[38:32];
    end
    d0 = n_delivered;
    saw_not_ready = 0;
    bi = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid  = (bi < 4);
      in_data   = bd[bi % 4];
      in_chk    = bc[bi % 4];
      chk_en    = 1'b1;
      out_ready = !(cyc >= 2 && cyc <= 4);
      cycle(acc);
      if (acc) bi++;
    end
    in_valid = 1'b0;
    check("stall_in_ready_dropped", saw_not_ready, 1);
    check("stall_delivered", n_delivered - d0, 4);
    check("stall_corr_cnt", corr_cnt, 4);
    check("stall_pending", sb.size(), 0);

    // Saturation at CNT_W=4.
    clear_counters();
    run(20, 1'b1, 100, 100, 0);
    check("sat_corr_cnt", corr_cnt, 15);

    // Clear in the same cycle as a counted transfer.
    b = make_beat(1'b1);
    in_valid = 1'b1;
    in_data = b[31:0];
    in_chk = b[38:32];
    chk_en = 1'b1;
    out_ready = 1'b0;
    cycle(acc);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 10) begin
      cycle(acc);
      guard++;
    end
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    cycle(acc);
    cnt_clr = 1'b0;
    check("clr_wins_corr_cnt", corr_cnt, 0);
    check("clr_wins_pending", sb.size(), 0);

    // Randomized traffic with mixed errors, stalls and occasional clears.
    run(300, 1'b0, 70, 60, 3);

    // Reset with both stages full.
    run(1, 1'b1, 100, 100, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = make_beat(1'b0);
      in_valid = 1'b1;
      in_data = b[31:0];
      in_chk = b[38:32];
      chk_en = b[39];
      cycle(acc);
    end
    in_valid = 1'b0;
    check("pre_reset_full", out_valid, 1);
    Grst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_corr_cnt", corr_cnt, 0);
    check("rst_uncorr_cnt", uncorr_cnt, 0);
    check("rst_out_data", out_data, 0);
    sb.delete();
    m_corr = 0;
    m_unc = 0;
    stall_prev = 0;
    @(negedge Gclk);
    Grst = 1'b0;
    #1;
    check("rst_release_in_ready_low", in_ready, 0);
    @(posedge Gclk);
    @(negedge Gclk);
    check("rst_release_in_ready_high", in_ready, 1);
    in_valid = 1'b1;
    in_data = BASE ^ 32'h0000_0020;
    in_chk = enc(BASE);
    chk_en = 1'b1;
    out_ready = 1'b1;
    cycle(acc);
    check("post_rst_accept", acc, 1);
    in_valid = 1'b0;
    check("post_rst_lat_s1_only", out_valid, 0);
    cycle(acc);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, BASE);
    cycle(acc);
    check("post_rst_corr_cnt", corr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/secded_pipe_corrector.md
Name: secded_pipe_corrector

Overview:
- Parametrised, pipelined successor to the combinational 32-bit single-error corrector in the ISCAS85 set.
- Takes a DATA_W data word plus extended-Hamming check bits and recomputes the syndrome.
- Corrects any single-bit error and detects double-bit errors.
- Adds valid/ready flow control, per-beat status, error location and saturating error counters; used as the ECC benchmark wrapper in the sequential benchmark set.

Parameters:
DATA_W, 32, data word width (legal 8..64)
P, derived, Hamming parity count: smallest p with 2^p >= DATA_W+p+1 (6 for 32); never overridden
CHK_W, derived, P+1 check bits (7 for 32)
CNT_W, 16, width of each saturating error counter

Ports:
Gclk  in  1  clock, all state on rising edge
Grst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat
in_data  in  DATA_W  received data
in_chk  in  CHK_W  received check bits: [P-1:0] Hamming parity, [P] overall parity
chk_en  in  1  sampled with beat; 0 = bypass correction (gate role of Gr)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  corrected data
out_status  out  2  0 OK, 1 CORR_DATA, 2 CORR_CHK, 3 UNCORR
out_err_pos  out  P  codeword position of corrected bit, 0 otherwise
corr_cnt  out  CNT_W  beats with status 1 or 2, saturating
uncorr_cnt  out  CNT_W  beats with status 3, saturating
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset: all outputs 0 while Grst high, except in_ready=1 from the first edge after release. Pipe is emptied and counters are zeroed. A beat in flight at reset is dropped.
- Code layout: codeword positions 1..N, where N=DATA_W+P. Data bits occupy non-power-of-two positions in ascending order (bit0->3, bit1->5, bit2->6, bit3->7, bit4->9, bit5->10, ...). Position 2^i holds in_chk[i]. in_chk[P] = XOR of all N positions.
- Syndrome: s = recomputed parity XOR in_chk[P-1:0]. o = XOR of all data and all in_chk bits.
- Classification:
  - s=0, o=0: OK.
  - o=1, s maps to a data position: flip that bit, CORR_DATA, err_pos=s.
  - o=1, s=0 or s a power of two: CORR_CHK, data unchanged, err_pos=s.
  - o=0, s!=0: UNCORR, data passed raw, err_pos=0.
  - o=1, s>N: UNCORR.
- chk_en=0: status OK, data raw, err_pos=0, counters untouched.
- Pipeline:
  - S1 registers the input and the syndrome; S2 registers the corrected result.
  - Latency is exactly 2 cycles from the accept edge to out_valid when there is no stall.
  - Throughput is 1 beat per cycle.
- Handshake:
  - Accept on in_valid&in_ready. Output transfer on out_valid&out_ready.
  - Stall when out_valid&!out_ready: S2 holds, and S1 advances only into an empty S2.
  - in_ready = !S1_full | S1 advancing; it is a combinational function of registered state and out_ready only, never of in_valid.
  - out_* is stable while stalled.
  - Order is preserved; no beat is dropped or duplicated.
- Counters:
  - Increment at the S2 output transfer, not at load, so a stalled beat counts once.
  - Saturate at all-ones with no wrap.
  - cnt_clr wins over a same-cycle increment; the result is 0.

Optional Feature:
- Macro: SECDED_ERR_INJECT_EN.
- Defined: adds ports inj_en (in 1) and inj_pos (in P). On an accepted beat with inj_en=1 and 1<=inj_pos<=N, the codeword bit at inj_pos is flipped before syndrome compute. inj_pos=0 or inj_pos>N injects nothing.
- Undefined: no ports and no logic.

Decomposition:
- Package secded_pkg holds:
  - function calc_p(DATA_W);
  - function data_pos(idx, DATA_W) returning the codeword position;
  - status enum typedef (ST_OK, ST_CORR_DATA, ST_CORR_CHK, ST_UNCORR);
  - constant STATUS_W=2.
- One combinational sub-module, secded_syndrome: {data, chk} -> {s, o}. It is reused by the bench's encoder model with the received chk set to zero.

Test Plan:
- DATA_W=32, data 0xDEADBEEF with correct chk, out_ready=1 -> after 2 cycles out_data=0xDEADBEEF, status 0, err_pos 0, counters 0.
- Same word with data bit5 flipped (0xDEADBECF) -> out_data 0xDEADBEEF, status 1, err_pos 10, corr_cnt=1.
- Data bits 0 and 1 flipped (0xDEADBEEC) -> out_data 0xDEADBEEC, status 3, uncorr_cnt=1; with chk_en=0 -> status 0, counters unchanged.
- Four back-to-back beats, out_ready low for 3 cycles from cycle 2 -> in_ready deasserts, out_data held stable, all 4 delivered in order, each counted once.
- CNT_W=4, 20 single-error beats -> corr_cnt=15. cnt_clr pulsed concurrently with a counted transfer -> corr_cnt=0.
- Grst asserted mid-stream with S1 and S2 full -> out_valid=0 immediately, counters 0, first post-reset beat appears 2 cycles after its accept.
